ring_seq_ctrl: RTL and testbench

Sequencer for the 8-bit ring-counter datapath. It replaces the free-running divided clock with a single-clock enable scheme. On a start command it loads a seed pattern into the ring register, then issues a programmed number of shift-enable pulses at a programmable rate and direction. It signals completion with a one-cycle done pulse. It sits between the board-level control inputs and the ring shifter, and all of them share the system clock.

---
 rtl/ring_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_ring_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_seq_ctrl.sv
// Ring-counter sequencer: loads a seed, then issues rate-divided shift enables.
// Define RING_SEQ_AUTOREV_EN for bounce mode (second leg in the opposite direction).
module ring_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] steps,
    input  logic [DIV_W-1:0] div,
    input  logic             dir_in,
    output logic             ld,
    output logic [WIDTH-1:0] ld_data,
    output logic             shift_en,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             dir_q, dir_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] rem_q, rem_d;
`ifdef RING_SEQ_AUTOREV_EN
    logic             leg_q, leg_d;
`endif
    logic             tick;

    assign tick = (presc_q == div_q);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        pat_d   = pat_q;
        steps_d = steps_q;
        div_d   = div_q;
        dir_d   = dir_q;
        presc_d = presc_q;
        rem_d   = rem_q;
`ifdef RING_SEQ_AUTOREV_EN
        leg_d   = leg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    pat_d   = pattern;
                    steps_d = steps;
                    div_d   = div;
                    dir_d   = dir_in;
`ifdef RING_SEQ_AUTOREV_EN
                    leg_d   = 1'b0;
`endif
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    presc_d = '0;
                    rem_d   = steps_q;
                    state_d = (steps_q == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    presc_d = '0;
                    rem_d   = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
`ifdef RING_SEQ_AUTOREV_EN
                        // First leg ending turns around instead of finishing.
                        if (!leg_q) begin
                            leg_d = 1'b1;
                            dir_d = ~dir_q;
                            rem_d = steps_q;
                        end else begin
                            state_d = S_DONE;
                        end
`else
                        state_d = S_DONE;
`endif
                    end
                end else begin
                    presc_d = presc_q + DIV_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            steps_q <= '0;
            div_q   <= '0;
            dir_q   <= 1'b0;
            presc_q <= '0;
            rem_q   <= '0;
`ifdef RING_SEQ_AUTOREV_EN
            leg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            steps_q <= steps_d;
            div_q   <= div_d;
            dir_q   <= dir_d;
            presc_q <= presc_d;
            rem_q   <= rem_d;
`ifdef RING_SEQ_AUTOREV_EN
            leg_q   <= leg_d;
`endif
        end
    end

    assign ld        = (state_q == S_LOAD);
    assign ld_data   = pat_q;
    assign shift_en  = (state_q == S_RUN) && tick;
    assign dir       = dir_q;
    assign busy      = (state_q == S_LOAD) || (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign remaining = rem_q;

endmodule

// File: tb/tb_ring_seq_ctrl.sv
// Self-checking bench for ring_seq_ctrl: timing-formula model compared every cycle
// plus directed commands with hand-computed event masks (relative cycle = bit index).
module tb_ring_seq_ctrl;
    localparam int WIDTH = 8;
    localparam int CNT_W = 8;
    localparam int DIV_W = 16;
`ifdef RING_SEQ_AUTOREV_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             clr = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [WIDTH-1:0] pattern = '0;
    logic [CNT_W-1:0] steps = '0;
    logic [DIV_W-1:0] div = '0;
    logic             dir_in = 1'b0;
    logic             ld;
    logic [WIDTH-1:0] ld_data;
    logic             shift_en;
    logic             dir;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remaining;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    ring_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
        .clk(clk), .clr(clr), .start(start), .stop(stop), .pattern(pattern),
        .steps(steps), .div(div), .dir_in(dir_in), .ld(ld), .ld_data(ld_data),
        .shift_en(shift_en), .dir(dir), .busy(busy), .done(done), .remaining(remaining)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: one command described by its accept cycle and the timing formulas.
    bit               m_act = 1'b0;
    int               m_c0 = 0;
    int               m_last = 0;
    int               m_t = 0;
    int               m_steps = 0;
    int               m_p = 1;
    bit               m_dir0 = 1'b0;
    logic [WIDTH-1:0] m_pat = '0;
    int               m_rem_hold = 0;
    bit               m_dir_hold = 1'b0;

    bit          rec = 1'b0;
    int          base = 0;
    logic [31:0] ld_m, sh_m, dn_m, bs_m, dr_m;

    task automatic model_sample(input int t);
        int rel;
        if (!clr) begin
            m_act      = 1'b0;
            m_rem_hold = 0;
            m_dir_hold = 1'b0;
            return;
        end
        rel = t - m_c0;
        if (!m_act || t > m_last) begin
            if (start && !stop) begin
                m_act   = 1'b1;
                m_c0    = t;
                m_steps = int'(steps);
                m_p     = int'(div) + 1;
                m_dir0  = dir_in;
                m_pat   = pattern;
                m_t     = 2 + (BOUNCE ? 2 * m_steps : m_steps) * m_p;
                m_last  = t + m_t;
            end
        end else if (stop && rel >= 1 && rel < m_t) begin
            m_last = t;
        end
    endtask

    task automatic compare_cycle(input int u);
        logic e_ld, e_sh, e_bs, e_dn, e_dir;
        int   e_rem, rel, s;
        bit   rem_chk, leg2;
        e_ld = 1'b0; e_sh = 1'b0; e_bs = 1'b0; e_dn = 1'b0;
        e_dir = m_dir_hold; e_rem = m_rem_hold; rem_chk = 1'b1;
        rel = u - m_c0;
        if (m_act && rel >= 1 && u <= m_last) begin
            if (rel == 1) begin
                e_ld = 1'b1; e_bs = 1'b1; e_dir = m_dir0; rem_chk = 1'b0;
            end else begin
                s     = (rel - 2) / m_p;
                leg2  = BOUNCE && m_steps > 0 && s >= m_steps;
                e_rem = leg2 ? 2 * m_steps - s : m_steps - s;
                e_dir = m_dir0 ^ leg2;
                if (rel == m_t) begin
                    e_dn = 1'b1;
                end else begin
                    e_bs = 1'b1;
                    e_sh = ((rel - 1) % m_p) == 0;
                end
            end
        end
        m_dir_hold = e_dir;
        if (rem_chk) m_rem_hold = e_rem;
        check("m.ld", 32'(ld), 32'(e_ld));
        check("m.shift_en", 32'(shift_en), 32'(e_sh));
        check("m.busy", 32'(busy), 32'(e_bs));
        check("m.done", 32'(done), 32'(e_dn));
        check("m.dir", 32'(dir), 32'(e_dir));
        if (rem_chk) check("m.remaining", 32'(remaining), 32'(e_rem));
        if (e_ld) check("m.ld_data", 32'(ld_data), 32'(m_pat));
        rel = u - base;
        if (rec && rel >= 0 && rel < 32) begin
            if (ld)             ld_m[rel] = 1'b1;
            if (shift_en)       sh_m[rel] = 1'b1;
            if (done)           dn_m[rel] = 1'b1;
            if (busy)           bs_m[rel] = 1'b1;
            if (shift_en & dir) dr_m[rel] = 1'b1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_sample(cyc);
            cyc++;
            #1;
            compare_cycle(cyc);
        end
    end

    task automatic clear_masks();
        ld_m = '0; sh_m = '0; dn_m = '0; bs_m = '0; dr_m = '0;
    endtask

    task automatic check_masks(input string name, input logic [31:0] x_ld, input logic [31:0] x_sh,
                               input logic [31:0] x_dn, input logic [31:0] x_bs, input logic [31:0] x_dr);
        check({name, ".ld_cycles"}, ld_m, x_ld);
        check({name, ".shift_cycles"}, sh_m, x_sh);
        check({name, ".done_cycles"}, dn_m, x_dn);
        check({name, ".busy_cycles"}, bs_m, x_bs);
        check({name, ".dir1_shift_cycles"}, dr_m, x_dr);
    endtask

    // Start in relative cycle 0; optional ignored start / stop pulses at given relative cycles.
    task automatic run_cmd(input string name, input logic [7:0] p, input logic [7:0] st,
                           input logic [15:0] dv, input logic d, input int ign_at, input int stop_at,
                           input int budget, input logic [31:0] x_ld, input logic [31:0] x_sh,
                           input logic [31:0] x_dn, input logic [31:0] x_bs, input logic [31:0] x_dr);
        @(negedge clk);
        pattern = p; steps = st; div = dv; dir_in = d; start = 1'b1; stop = 1'b0;
        base = cyc;
        clear_masks();
        rec = 1'b1;
        for (int r = 1; r <= budget; r++) begin
            @(negedge clk);
            start   = (r == ign_at);
            stop    = (r == stop_at);
            pattern = ~p;
            steps   = st + 8'd1;
            div     = dv + 16'd3;
            dir_in  = ~d;
        end
        start = 1'b0; stop = 1'b0; rec = 1'b0;
        check_masks(name, x_ld, x_sh, x_dn, x_bs, x_dr);
    endtask

    task automatic check_all_zero(input string name);
        check({name, ".ld"}, 32'(ld), 32'd0);
        check({name, ".ld_data"}, 32'(ld_data), 32'd0);
        check({name, ".shift_en"}, 32'(shift_en), 32'd0);
        check({name, ".dir"}, 32'(dir), 32'd0);
        check({name, ".busy"}, 32'(busy), 32'd0);
        check({name, ".done"}, 32'(done), 32'd0);
        check({name, ".remaining"}, 32'(remaining), 32'd0);
    endtask

`ifdef RING_SEQ_AUTOREV_EN
    localparam logic [31:0] B_SH = 32'h0009_2490, B_DN = 32'h0010_0000, B_BS = 32'h000F_FFFE, B_DR = 32'h0009_2000;
    localparam logic [31:0] F_SH = 32'h0000_03FC, F_DN = 32'h0000_0400, F_BS = 32'h0000_03FE, F_DR = 32'h0000_003C;
    localparam logic [31:0] R_SH = 32'h0000_02A8, R_DN = 32'h0000_0400, R_BS = 32'h0000_03FE, R_DR = 32'h0000_0280;
`else
    localparam logic [31:0] B_SH = 32'h0000_0490, B_DN = 32'h0000_0800, B_BS = 32'h0000_07FE, B_DR = 32'h0000_0000;
    localparam logic [31:0] F_SH = 32'h0000_003C, F_DN = 32'h0000_0040, F_BS = 32'h0000_003E, F_DR = 32'h0000_003C;
    localparam logic [31:0] R_SH = 32'h0000_0028, R_DN = 32'h0000_0040, R_BS = 32'h0000_003E, R_DR = 32'h0000_0000;
`endif

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        clr = 1'b1;

        // Idle: nothing for 20 cycles; a start qualified by stop is ignored.
        @(negedge clk);
        base = cyc;
        clear_masks();
        rec = 1'b1;
        for (int r = 1; r <= 20; r++) begin
            @(negedge clk);
            start = (r == 7);
            stop  = (r == 7);
        end
        start = 1'b0; stop = 1'b0; rec = 1'b0;
        check_masks("idle", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

        run_cmd("basic", 8'h01, 8'd3, 16'd2, 1'b0, 4, 0, 24, 32'h2, B_SH, B_DN, B_BS, B_DR);
        check("basic.remaining_end", 32'(remaining), 32'd0);
        run_cmd("fast", 8'h81, 8'd4, 16'd0, 1'b1, 0, 0, 14, 32'h2, F_SH, F_DN, F_BS, F_DR);
        run_cmd("zero_steps", 8'h5A, 8'd0, 16'd7, 1'b0, 0, 0, 14, 32'h2, 32'h0, 32'h4, 32'h2, 32'h0);
        run_cmd("abort", 8'h0F, 8'd5, 16'd1, 1'b0, 0, 6, 14, 32'h2, 32'h28, 32'h0, 32'h7E, 32'h0);
        check("abort.remaining_held", 32'(remaining), 32'd3);
        run_cmd("bounce", 8'h11, 8'd2, 16'd1, 1'b0, 0, 0, 14, 32'h2, R_SH, R_DN, R_BS, R_DR);

        // Reset in cycle 5 of a steps=5, div=1 run.
        @(negedge clk);
        pattern = 8'hC3; steps = 8'd5; div = 16'd1; dir_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst.busy_before", 32'(busy), 32'd1);
        check("midrst.dir_before", 32'(dir), 32'd1);
        clr = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) @(negedge clk);
        clr = 1'b1;
        run_cmd("after_rst", 8'h01, 8'd3, 16'd2, 1'b0, 0, 0, 24, 32'h2, B_SH, B_DN, B_BS, B_DR);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
